// File: rtl/pipeline_run_ctrl.sv
// Run controller for the pipeline enable: executes host STEP / RUN_N / RUN_FREE / HALT
// commands, stops on a PC breakpoint and counts the enabled cycles of the current run.
module pipeline_run_ctrl #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [PC_W-1:0]  pc,
    input  logic             brk_en,
    input  logic [PC_W-1:0]  brk_addr,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [1:0]       halt_reason,
    output logic [CNT_W-1:0] cycles_run
);

    localparam logic [1:0] OP_HALT     = 2'b00;
    localparam logic [1:0] OP_STEP     = 2'b01;
    localparam logic [1:0] OP_RUN_N    = 2'b10;
    localparam logic [1:0] OP_RUN_FREE = 2'b11;

    localparam logic [1:0] RSN_NONE  = 2'b00;
    localparam logic [1:0] RSN_COUNT = 2'b01;
    localparam logic [1:0] RSN_BRK   = 2'b10;
    localparam logic [1:0] RSN_HOST  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STEP     = 3'd1,
        ST_RUN_N    = 3'd2,
        ST_RUN_FREE = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] remaining_r;
    logic [CNT_W-1:0] cycles_r;
    logic [1:0]       reason_r;
    logic             first_r;

    logic running_s;
    logic brk_hit_s;
    logic halt_acc_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // State decode for the handshake and status outputs
    always_comb begin
        running_s = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_STEP, ST_RUN_N, ST_RUN_FREE: begin
                running_s = 1'b1;
                busy      = 1'b1;
                cmd_ready = (cmd_op == OP_HALT);
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // first_r masks the compare so a run started on the breakpoint PC moves past it
    assign brk_hit_s  = brk_en & (pc == brk_addr) & ~first_r;
    assign enable     = running_s & ~brk_hit_s;
    assign halt_acc_s = running_s & cmd_valid & cmd_ready;

    assign halt_reason = reason_r;
    assign cycles_run  = cycles_r;

    // Run sequencing, counters and stop reason
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= CNT_ZERO;
            cycles_r    <= CNT_ZERO;
            reason_r    <= RSN_NONE;
            first_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_STEP: begin
                                state_r  <= ST_STEP;
                                first_r  <= 1'b1;
                                cycles_r <= CNT_ZERO;
                                reason_r <= RSN_NONE;
                            end
                            OP_RUN_N: begin
                                cycles_r <= CNT_ZERO;
                                if (cmd_count != CNT_ZERO) begin
                                    state_r     <= ST_RUN_N;
                                    remaining_r <= cmd_count;
                                    first_r     <= 1'b1;
                                    reason_r    <= RSN_NONE;
                                end else begin
                                    state_r  <= ST_DONE;
                                    reason_r <= RSN_COUNT;
                                end
                            end
                            OP_RUN_FREE: begin
                                state_r  <= ST_RUN_FREE;
                                first_r  <= 1'b1;
                                cycles_r <= CNT_ZERO;
                                reason_r <= RSN_NONE;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_STEP, ST_RUN_N, ST_RUN_FREE: begin
                    first_r <= 1'b0;
                    if (brk_hit_s) begin
                        state_r  <= ST_DONE;
                        reason_r <= RSN_BRK;
                    end else begin
                        cycles_r <= sat_inc(cycles_r);
                        if (state_r == ST_RUN_N) begin
                            remaining_r <= remaining_r - CNT_ONE;
                        end
                        if (halt_acc_s) begin
                            state_r  <= ST_DONE;
                            reason_r <= RSN_HOST;
                        end else if ((state_r == ST_STEP) ||
                                     ((state_r == ST_RUN_N) && (remaining_r == CNT_ONE))) begin
                            state_r  <= ST_DONE;
                            reason_r <= RSN_COUNT;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: a 16-bit-counter instance drives a simple PC model,
// a 4-bit-counter instance shares the same stimulus to exercise counter saturation.
module tb_pipeline_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic [31:0] pc;
    logic        brk_en;
    logic [31:0] brk_addr;

    logic        cmd_ready, enable, busy, done;
    logic [1:0]  halt_reason;
    logic [15:0] cycles_run;

    logic        cmd_ready4, enable4, busy4, done4;
    logic [1:0]  halt_reason4;
    logic [3:0]  cycles_run4;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [1:0] HALT = 2'b00, STEP = 2'b01, RUN_N = 2'b10, RUN_FREE = 2'b11;

    always #5 clk = ~clk;

    pipeline_run_ctrl #(.CNT_W(16), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .pc(pc), .brk_en(brk_en),
        .brk_addr(brk_addr), .enable(enable), .busy(busy), .done(done),
        .halt_reason(halt_reason), .cycles_run(cycles_run)
    );

    pipeline_run_ctrl #(.CNT_W(4), .PC_W(32)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_count(cmd_count[3:0]), .pc(pc), .brk_en(brk_en),
        .brk_addr(brk_addr), .enable(enable4), .busy(busy4), .done(done4),
        .halt_reason(halt_reason4), .cycles_run(cycles_run4)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: the pipeline PC advances by 4 after every enabled cycle
    task automatic cyc();
        logic en_q;
        en_q = enable;
        @(negedge clk);
        if (en_q === 1'b1) pc = pc + 32'd4;
        #2;
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [15:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        #1;
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int max, output int n_en, output int n_cyc);
        n_en  = 0;
        n_cyc = 0;
        while (done !== 1'b1 && n_cyc < max) begin
            if (enable === 1'b1) n_en++;
            cyc();
            n_cyc++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n_en, n_cyc;
        logic stall_seen;

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = HALT; cmd_count = 16'd0;
        pc = 32'd0; brk_en = 1'b0; brk_addr = 32'd0;
        #2;
        chk("rst_enable", {31'd0, enable}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_reason", {30'd0, halt_reason}, 32'd0);
        chk("rst_cycles", {16'd0, cycles_run}, 32'd0);
        chk("rst_ready4", {30'd0, cmd_ready4, enable4}, 32'd2);
        cyc();
        rst = 1'b1;
        cyc();

        // STEP: one enable cycle, DONE, then IDLE
        issue("step", STEP, 16'd0);
        chk("step_enable", {31'd0, enable}, 32'd1);
        chk("step_busy", {31'd0, busy}, 32'd1);
        cyc();
        chk("step_done", {31'd0, done}, 32'd1);
        chk("step_done_en", {30'd0, enable, busy}, 32'd0);
        chk("step_done_ready", {31'd0, cmd_ready}, 32'd0);
        chk("step_reason", {30'd0, halt_reason}, 32'd1);
        chk("step_cycles", {16'd0, cycles_run}, 32'd1);
        cyc();
        chk("step_idle_done", {31'd0, done}, 32'd0);
        chk("step_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // HALT while idle is a no-op
        issue("idle_halt", HALT, 16'd0);
        chk("idle_halt_state", {30'd0, done, busy}, 32'd0);
        chk("idle_halt_reason", {30'd0, halt_reason}, 32'd1);

        // RUN_N 5
        issue("run5", RUN_N, 16'd5);
        run_until_done("run5", 50, n_en, n_cyc);
        chk("run5_en_cycles", n_en, 32'd5);
        chk("run5_done_cycle", n_cyc, 32'd5);
        chk("run5_cycles", {16'd0, cycles_run}, 32'd5);
        chk("run5_reason", {30'd0, halt_reason}, 32'd1);
        chk("run5_cycles4", {28'd0, cycles_run4}, 32'd5);
        cyc();

        // RUN_N 0: straight to DONE
        issue("run0", RUN_N, 16'd0);
        chk("run0_done", {31'd0, done}, 32'd1);
        chk("run0_enable", {31'd0, enable}, 32'd0);
        chk("run0_cycles", {16'd0, cycles_run}, 32'd0);
        chk("run0_reason", {30'd0, halt_reason}, 32'd1);
        cyc();

        // RUN_FREE into breakpoint at 0x10, then STEP off it
        pc = 32'd0; brk_addr = 32'h10; brk_en = 1'b1;
        issue("brk", RUN_FREE, 16'd0);
        run_until_done("brk", 50, n_en, n_cyc);
        chk("brk_en_cycles", n_en, 32'd4);
        chk("brk_pc", pc, 32'h10);
        chk("brk_reason", {30'd0, halt_reason}, 32'd2);
        chk("brk_cycles", {16'd0, cycles_run}, 32'd4);
        cyc();
        issue("brkstep", STEP, 16'd0);
        chk("brkstep_enable", {31'd0, enable}, 32'd1);
        run_until_done("brkstep", 10, n_en, n_cyc);
        chk("brkstep_reason", {30'd0, halt_reason}, 32'd1);
        chk("brkstep_pc", pc, 32'h14);
        cyc();

        // Breakpoint and HALT in the same cycle: breakpoint wins
        pc = 32'h40; brk_addr = 32'h48;
        issue("bvh", RUN_FREE, 16'd0);
        cyc();
        cyc();
        cmd_valid = 1'b1; cmd_op = HALT;
        #1;
        chk("bvh_ready", {31'd0, cmd_ready}, 32'd1);
        chk("bvh_enable", {31'd0, enable}, 32'd0);
        cyc();
        cmd_valid = 1'b0;
        chk("bvh_done", {31'd0, done}, 32'd1);
        chk("bvh_reason", {30'd0, halt_reason}, 32'd2);
        chk("bvh_cycles", {16'd0, cycles_run}, 32'd2);
        cyc();

        // RUN_FREE with a stalled STEP, then HALT on the 8th enabled cycle
        brk_en = 1'b0;
        issue("halt", RUN_FREE, 16'd0);
        stall_seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cmd_valid = 1'b1; cmd_op = STEP;
            #1;
            stall_seen = stall_seen | cmd_ready | ~enable;
            cyc();
        end
        chk("halt_step_stalled", {31'd0, stall_seen}, 32'd0);
        cmd_op = HALT;
        #1;
        chk("halt_ready", {31'd0, cmd_ready}, 32'd1);
        chk("halt_enable", {31'd0, enable}, 32'd1);
        cyc();
        cmd_valid = 1'b0;
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_reason", {30'd0, halt_reason}, 32'd3);
        chk("halt_cycles", {16'd0, cycles_run}, 32'd8);
        cyc();

        // RUN_N 3 with breakpoint on the third cycle
        pc = 32'h100; brk_addr = 32'h108; brk_en = 1'b1;
        issue("n3brk", RUN_N, 16'd3);
        run_until_done("n3brk", 20, n_en, n_cyc);
        chk("n3brk_reason", {30'd0, halt_reason}, 32'd2);
        chk("n3brk_cycles", {16'd0, cycles_run}, 32'd2);
        cyc();
        brk_en = 1'b0;

        // 20 enabled cycles: 4-bit counter saturates at 15
        issue("sat", RUN_FREE, 16'd0);
        repeat (19) cyc();
        cmd_valid = 1'b1; cmd_op = HALT;
        cyc();
        cmd_valid = 1'b0;
        chk("sat_cycles16", {16'd0, cycles_run}, 32'd20);
        chk("sat_cycles4", {28'd0, cycles_run4}, 32'd15);
        chk("sat_done4", {29'd0, done4, halt_reason4}, 32'd7);
        cyc();

        // Asynchronous reset in the middle of RUN_N
        issue("rstmid", RUN_N, 16'd10);
        repeat (3) cyc();
        chk("rstmid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstmid_async", {29'd0, enable, busy, done}, 32'd0);
        chk("rstmid_async4", {30'd0, enable4, busy4}, 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rstmid_cycles", {16'd0, cycles_run}, 32'd0);
        chk("rstmid_state", {29'd0, enable, busy, done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Parametrised run controller that drives the processor pipeline's `enable` input. It replaces hand-toggled enable with host-issued commands: single-step, run-N-cycles, free-run and halt. It also provides a PC breakpoint and a count of executed cycles. It sits between the host/debug command source and the `pipeline` top, in the same clock domain.

## Interface
Parameters:
- `CNT_W`, 16, width of run count and cycle counter.
- `PC_W`, 32, width of pipeline PC and breakpoint address.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_op`  in  2  00 HALT, 01 STEP, 10 RUN_N, 11 RUN_FREE.
- `cmd_count`  in  CNT_W  cycle count for RUN_N; ignored otherwise.
- `pc`  in  PC_W  current fetch PC from the pipeline.
- `brk_en`  in  1  breakpoint enable.
- `brk_addr`  in  PC_W  breakpoint address.
- `enable`  out  1  pipeline advance enable.
- `busy`  out  1  high in any running state.
- `done`  out  1  one-cycle pulse when a run ends.
- `halt_reason`  out  2  00 none, 01 count/step complete, 10 breakpoint, 11 host halt; held until the next start.
- `cycles_run`  out  CNT_W  enabled cycles since the last accepted start; saturates at all-ones.

## Operation
- States: IDLE, STEP, RUN_N, RUN_FREE, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - STEP goes to STEP.
  - RUN_N with count ≥1 goes to RUN_N and loads `remaining`=count.
  - RUN_N with count 0 goes to DONE with reason 01 and no enable cycle.
  - RUN_FREE goes to RUN_FREE.
  - HALT is accepted and has no effect: no `done`, reason unchanged.
  - Any start clears `cycles_run` to 0 and `halt_reason` to 00.
- **Running states (STEP/RUN_N/RUN_FREE)**
  - `cmd_ready` = (`cmd_op`==HALT). Non-HALT commands stall.
  - `enable` = ~`brk_hit`.
  - `brk_hit` = `brk_en` & (`pc`==`brk_addr`) & ~`first`. `first` is high only in the first cycle of a run, so restarting from a breakpoint PC advances past it.
- **Run-state transitions.** Each `enable` cycle increments `cycles_run` and, in RUN_N, decrements `remaining`. End conditions, in priority order:
  - `brk_hit`: go to DONE, reason 10. `enable` is low in that cycle.
  - HALT accepted: go to DONE, reason 11. `enable` stays high in the acceptance cycle, so that cycle counts.
  - STEP after its one enable cycle, or RUN_N with `remaining`==1 on an enable cycle: go to DONE, reason 01.
  - RUN_FREE ends only by breakpoint or halt.
- **DONE**
  - `done`=1, `enable`=0, `busy`=0, `cmd_ready`=0.
  - Next state is IDLE.
- Outputs `busy` and `done` decode the registered state. `enable` is state AND the combinational breakpoint compare.

## Timing
- **Reset** (`rst`=0, asynchronous): state IDLE.
  - `enable`=0, `busy`=0, `done`=0, `cmd_ready`=1.
  - `halt_reason`=00, `cycles_run`=0, `remaining`=0, `first`=0.
  - Reset mid-run drops `enable` immediately, without waiting for a clock edge.
- **Start latency:** command accepted at edge T; `enable` is high in cycle T+1.
- **STEP:** `enable` is high for exactly 1 cycle, then DONE for 1 cycle, then IDLE. A new command can be accepted 3 cycles after the previous acceptance.
- **RUN_N with N:** `enable` is high for N consecutive cycles absent a breakpoint. DONE follows in the next cycle, then IDLE.
- **Simultaneous events in one cycle:** breakpoint beats halt beats count exhaustion.
- **Counters:**
  - `cycles_run` saturates at 2^CNT_W−1 and does not wrap.
  - `remaining` never underflows, because exit occurs at 1.

## Test plan
- Reset, then STEP at PC 0x0 with `brk_en`=0 -> `enable` high 1 cycle, `done` pulse next cycle, `halt_reason`=01, `cycles_run`=1.
- RUN_N count=5 -> `enable` high exactly 5 cycles, `done` on cycle 6, `cycles_run`=5, reason 01. RUN_N count=0 -> `done` 1 cycle after acceptance, `enable` never high, `cycles_run`=0.
- RUN_FREE with `brk_en`=1, `brk_addr`=0x10, `pc` advancing by 4 per enable from 0x0 -> 4 enable cycles, `enable` low when `pc`=0x10, reason 10, `cycles_run`=4. Re-issue STEP at `pc`=0x10 -> advances 1 cycle, no immediate re-hit.
- RUN_FREE, then HALT after 7 enable cycles -> acceptance cycle counts, `cycles_run`=8, reason 11. A STEP offered while running -> `cmd_ready`=0 until the run ends.
- RUN_N count=3 with the breakpoint hit on the 3rd cycle -> reason 10 (breakpoint wins), `cycles_run`=2. With CNT_W=4, RUN_FREE for 20 cycles -> `cycles_run`=15.
- `rst` asserted mid RUN_N -> `enable`, `busy` and `done` go low asynchronously; after release the controller is in IDLE, `cmd_ready`=1, `cycles_run`=0.
